pc_incr_unit: RTL and testbench

PC_INCR_UNIT -- requirements
Module: pc_incr_unit

---
 rtl/pc_incr_unit.sv | 152 +++++++++++++++
 tb/tb_pc_incr_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_incr_unit.sv
// -----------------------------------------------------------------------------
// pc_incr_unit
//
// Program-counter sequencer for an in-order fetch stage. Holds the current PC
// and advances it by 4, loads a branch/jump target, holds on stall and parks
// in HALT until resumed. pc_next exposes, combinationally, the value pc will
// take at the next rising edge, so fetch can start the next access early.
//
// Request priority in RUN and STALL: halt > ld > stall > en.
//
// Build option:
//   PC_ALIGN_CHECK_EN - when defined, a load whose target is not word
//                       aligned (target[1:0] != 2'b00) is rejected: pc holds,
//                       misalign pulses for one cycle and the unit halts.
//                       When undefined, targets load unmodified and misalign
//                       is tied low.
// -----------------------------------------------------------------------------
module pc_incr_unit #(
  parameter int unsigned       N        = 32,
  parameter logic [N-1:0]      RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         stall,
  input  logic         ld,
  input  logic [N-1:0] target,
  input  logic         halt,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_next,
  output logic         pc_valid,
  output logic         halted,
  output logic         misalign
);

  // Sequential instruction step; the carry out of the add is dropped, so the
  // top word of the address space wraps to zero.
  localparam logic [N-1:0] PC_STEP = N'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HALT  = 2'b11
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         pc_valid_q;
  logic         halted_q;
`ifdef PC_ALIGN_CHECK_EN
  logic         misalign_q, misalign_d;
`endif

  // Next-state and next-PC selection, applying halt > ld > stall > en.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    unique case (state_q)
      // First edge after reset release: start fetching at RESET_PC.
      IDLE: begin
        state_d = RUN;
      end

      // RUN and STALL share one decision tree; STALL only differs in that
      // dropping stall falls through to the en/no-request branches, which
      // return to RUN in the same cycle.
      RUN, STALL: begin
        if (halt) begin
          state_d = HALT;
        end else if (ld) begin
`ifdef PC_ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            // Misaligned branch target: refuse it, flag it, stop fetching.
            state_d    = HALT;
            misalign_d = 1'b1;
          end else
`endif
          begin
            pc_d    = target;
            state_d = RUN;
          end
        end else if (stall) begin
          state_d = STALL;
        end else if (en) begin
          pc_d    = pc_q + PC_STEP;
          state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end

      // Parked: only resume matters, and a simultaneous halt keeps us here.
      HALT: begin
        if (resume && !halt) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // State, PC and registered status flags; reset is immediate and drops any
  // load that was being requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= (state_d == RUN) || (state_d == STALL);
      halted_q   <= (state_d == HALT);
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle pulse on the edge that rejects a misaligned load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_next  = pc_d;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_incr_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_incr_unit
//
// Directed test of pc_incr_unit (N=32, RESET_PC=0). The driver applies one
// request per cycle on the falling edge, checks pc_next against the PC it
// expects after the coming edge, and pushes that expected post-edge state into
// a queue. A monitor pops one entry after every rising edge and compares
// pc, pc_valid, halted and misalign. The asynchronous-reset checks happen
// between edges and are made directly by the driver.
// Builds with or without PC_ALIGN_CHECK_EN; the misaligned-load expectations
// follow the macro.
// -----------------------------------------------------------------------------
module tb_pc_incr_unit;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        misalign;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, ld, halt, resume;
  logic [31:0] target;
  logic [31:0] pc, pc_next;
  logic        pc_valid, halted, misalign;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  pc_incr_unit #(
    .N        (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .stall    (stall),
    .ld       (ld),
    .target   (target),
    .halt     (halt),
    .resume   (resume),
    .pc       (pc),
    .pc_next  (pc_next),
    .pc_valid (pc_valid),
    .halted   (halted),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus plus the state expected after the next rising edge.
  task automatic step(input logic i_en, input logic i_stall, input logic i_ld,
                      input logic [31:0] i_target, input logic i_halt, input logic i_resume,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_halted,
                      input logic e_misalign);
    exp_t e;
    @(negedge clk);
    en     = i_en;
    stall  = i_stall;
    ld     = i_ld;
    target = i_target;
    halt   = i_halt;
    resume = i_resume;
    #1;
    check("pc_next", pc_next, e_pc);
    e.pc       = e_pc;
    e.valid    = e_valid;
    e.halted   = e_halted;
    e.misalign = e_misalign;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the registered outputs after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",       pc,              e.pc);
        check("pc_valid", 32'(pc_valid),   32'(e.valid));
        check("halted",   32'(halted),     32'(e.halted));
        check("misalign", 32'(misalign),   32'(e.misalign));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    stall  = 1'b0;
    ld     = 1'b0;
    halt   = 1'b0;
    resume = 1'b0;
    target = 32'h0;

    // Reset state.
    #12;
    check("rst pc",       pc,             32'h0);
    check("rst pc_valid", 32'(pc_valid),  32'h0);
    check("rst halted",   32'(halted),    32'h0);
    check("rst misalign", 32'(misalign),  32'h0);

    // Release reset with en held: 0 (IDLE), 0, 4, 8, 12.
    @(posedge clk);
    #2 rst_n = 1'b1;
    //    en stall ld target        halt res  pc            v  h  m
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0000, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0008, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_000C, 1, 0, 0);

    // Wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0000, 1, 0, 0);

    // ld beats stall and en; then stall holds, release with en steps.
    step(0, 0, 1, 32'h100,      0, 0, 32'h0000_0100, 1, 0, 0);
    step(1, 1, 1, 32'h200,      0, 0, 32'h0000_0200, 1, 0, 0);
    step(0, 1, 0, 32'h0,        0, 0, 32'h0000_0200, 1, 0, 0);
    step(1, 1, 0, 32'h0,        0, 0, 32'h0000_0200, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0204, 1, 0, 0);
    step(0, 0, 0, 32'h0,        0, 0, 32'h0000_0204, 1, 0, 0);

    // Load from STALL returns to RUN.
    step(0, 1, 0, 32'h0,        0, 0, 32'h0000_0204, 1, 0, 0);
    step(0, 1, 1, 32'h300,      0, 0, 32'h0000_0300, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0304, 1, 0, 0);

    // Halt / resume at 0x40; requests ignored while halted.
    step(0, 0, 1, 32'h40,       0, 0, 32'h0000_0040, 1, 0, 0);
    step(1, 0, 0, 32'h0,        1, 0, 32'h0000_0040, 0, 1, 0);
    step(1, 1, 1, 32'h500,      0, 0, 32'h0000_0040, 0, 1, 0);
    step(1, 0, 1, 32'h504,      0, 0, 32'h0000_0040, 0, 1, 0);
    step(1, 1, 0, 32'h0,        0, 0, 32'h0000_0040, 0, 1, 0);
    step(0, 0, 0, 32'h0,        1, 1, 32'h0000_0040, 0, 1, 0);
    step(0, 0, 0, 32'h0,        0, 1, 32'h0000_0040, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0044, 1, 0, 0);

    // Misaligned load target.
`ifdef PC_ALIGN_CHECK_EN
    step(0, 0, 1, 32'h103,      0, 0, 32'h0000_0044, 0, 1, 1);
    step(0, 0, 0, 32'h0,        0, 0, 32'h0000_0044, 0, 1, 0);
    step(0, 0, 0, 32'h0,        0, 1, 32'h0000_0044, 1, 0, 0);
`else
    step(0, 0, 1, 32'h103,      0, 0, 32'h0000_0103, 1, 0, 0);
    step(0, 0, 0, 32'h0,        0, 0, 32'h0000_0103, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0107, 1, 0, 0);
`endif

    // Enter STALL at 0x80, then reset between edges.
    step(0, 0, 1, 32'h80,       0, 0, 32'h0000_0080, 1, 0, 0);
    step(0, 1, 0, 32'h0,        0, 0, 32'h0000_0080, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    ld     = 1'b1;
    target = 32'h999;
    #1;
    check("async pc",       pc,            32'h0);
    check("async pc_valid", 32'(pc_valid), 32'h0);
    check("async halted",   32'(halted),   32'h0);
    check("async misalign", 32'(misalign), 32'h0);
    // The load requested during reset must not take effect.
    @(posedge clk);
    #1;
    check("rst hold pc", pc, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0, 0, 0, 32'h0,        0, 0, 32'h0000_0000, 1, 0, 0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0);

    // Let the monitor consume the remaining expectations, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
